// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, FSM state type and the round-robin search used by the
// eight-way byte arbiter.
package rr_mux_arbiter_pkg;
    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    // Returns {found, idx}. The search walks downward so the candidate
    // closest to ptr is the last one written and therefore wins.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bus of the arbiter: request side, mux select and the
// registered valid/ready output stage.
interface rr_mux_arbiter_if;
    import rr_mux_arbiter_pkg::*;

    logic                     en;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*DATA_W-1:0]  din;
    logic [N_REQ-1:0]         gnt;
    logic [SEL_W-1:0]         sel;
    logic [DATA_W-1:0]        dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [CNT_W-1:0]         grant_cnt;

    modport master (output en, req, din, dout_ready,
                    input  gnt, sel, dout, dout_valid, grant_cnt);
    modport slave  (input  en, req, din, dout_ready,
                    output gnt, sel, dout, dout_valid, grant_cnt);
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin priority pick starting the search at ptr.
module rr_priority_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);
    assign {found, idx} = rr_pick(req, ptr);
    assign onehot       = found ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the shared 8:1 byte mux into a one-deep
// registered output stage with valid/ready flow control.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N     = N_REQ
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_if.slave   bus
);
    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [N-1:0]     onehot;
    logic             load_slot;
    logic             capture;

    rr_priority_pick u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .found  (found),
        .idx    (idx),
        .onehot (onehot)
    );

    // The output slot is free when empty or when its byte leaves this cycle.
    // Gating with rst_n keeps gnt quiet while reset is held.
    assign load_slot = (state == IDLE) || bus.dout_ready;
    assign capture   = rst_n && load_slot && bus.en && found;
    assign bus.gnt   = capture ? onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            bus.sel        <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.grant_cnt  <= '0;
        end else if (capture) begin
            state          <= FULL;
            ptr            <= idx + SEL_W'(1);
            bus.sel        <= idx;
            bus.dout       <= bus.din[WIDTH*idx +: WIDTH];
            bus.dout_valid <= 1'b1;
            if (bus.grant_cnt != '1)
                bus.grant_cnt <= bus.grant_cnt + CNT_W'(1);
        end else if (state == FULL && bus.dout_ready) begin
            state          <= IDLE;
            bus.dout_valid <= 1'b0;
        end
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares the 8-way, 8-bit multiplexer datapath between eight requesters.
- It picks one requester and drives the 3-bit select for that requester's data. It captures the selected byte into a registered output stage, then presents it downstream with a valid/ready handshake.
- It sits between the eight byte producers and a single downstream consumer, replacing a free-running select with a fair, flow-controlled one.

Parameters:
- WIDTH, 8, data width of each requester byte and of the output.
- N, 8, number of requesters. Fixed at 8 because the select is 3 bits; other values are unsupported.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; when low, no new grants are issued.
- req  input  8  request vector; bit i means requester i has a valid byte.
- din  input  64  packed requester data; requester i occupies din[8*i+7 : 8*i].
- gnt  output  8  one-hot, one-cycle pulse: requester i's byte was captured this cycle.
- sel  output  3  index of the last granted requester (mux select).
- dout  output  8  registered output byte.
- dout_valid  output  1  dout holds an unconsumed byte.
- dout_ready  input  1  downstream accepts dout this cycle.
- grant_cnt  output  16  saturating count of grants since reset.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_valid=0, sel=0, gnt=0, grant_cnt=0, rr pointer ptr=0, state=IDLE.
- Reset mid-transfer discards any held byte; no gnt pulse is issued for it.
- Round-robin pick: the first i with req[i]=1, searching ptr, ptr+1, …, ptr+7 mod 8. After a grant to i, ptr becomes (i+1) mod 8 (wraps 7 -> 0).
- "Load slot" is defined as: state=IDLE, or state=FULL with dout_ready=1.
- Capture: in a cycle where the load slot is true, en=1 and req is nonzero:
  - the picked byte din[8*i+:8] is registered into dout, and sel<=i;
  - gnt[i] pulses for exactly that cycle (combinational from the same decision, all other bits 0);
  - dout_valid<=1, grant_cnt increments (saturates at 16'hFFFF), state<=FULL.
- FULL with dout_ready=0: dout, dout_valid and sel are held stable; gnt=0; req is ignored.
- FULL with dout_ready=1 and no capture (en=0 or req=0): dout_valid<=0, state<=IDLE; dout keeps its last value.
- Back-to-back: accept and capture in the same cycle sustains one byte per cycle with no bubble.
- Latency: req asserted in cycle n while IDLE gives dout_valid=1 in cycle n+1.
- Requester contract: on gnt[i], the requester drops req[i] or presents its next byte by the next edge. The arbiter never samples din from a requester without granting it.
- en=0 blocks new captures only; a byte already in FULL still completes its handshake.
- sel changes only on a capture.
- IDLE with dout_ready=1 has no effect.

Decomposition:
- Shared package holds:
  - constant N_REQ=8, SEL_W=3, DATA_W=8, CNT_W=16;
  - state enum {IDLE, FULL};
  - a function rr_pick(req, ptr) returning {found, idx}.
- One natural sub-module: rr_priority_pick. It is combinational and takes req[7:0] and ptr[2:0], returning found, idx[2:0] and onehot[7:0]. The top keeps the FSM, the output register and the counter.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF, then release -> dout=0, dout_valid=0, gnt=0, sel=0, grant_cnt=0; the first grant goes to requester 0.
- Fairness: req=8'hFF held, dout_ready=1, din bytes i=8'hA0+i -> gnt walks 01,02,04,…,80,01; dout sequence A0..A7,A0 at one byte per cycle; grant_cnt=9 after 9 grants.
- Wrap and skip: ptr=6 (last grant to 5), req=8'b0000_0101 -> gnt=01 (requester 0), sel=0, next ptr=1; then req=8'b0000_0100 -> gnt=04.
- Backpressure: capture 8'h3C from requester 2, then hold dout_ready=0 for 5 cycles with req=8'hFF -> dout=3C and dout_valid=1 stable, gnt=0, sel=2. Raising dout_ready gives an accept and capture of requester 3 in the same cycle.
- Enable gating: en=0 with req=8'h10 -> no gnt and dout_valid stays 0. A held byte with en=0 and dout_ready=1 -> dout_valid drops and state returns to IDLE.
- Async reset mid-FULL: assert rst_n=0 between edges while dout_valid=1 -> dout_valid=0 and dout=0 immediately without a clock; grant_cnt=0.
